frame_config_loader: RTL and testbench



---
 rtl/frame_config_loader.sv | 185 ++++++++++++++++++
 tb/tb_frame_config_loader.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_config_loader.sv
// Frame configuration loader: turns a synchronised 32-bit word stream into FrameData plus one-hot FrameStrobe pulses.
// Optional FRAME_CHECKSUM_EN adds a per-packet check word after the last frame of each write packet.
module frame_config_loader #(
    parameter int unsigned FrameBitsPerRow = 32,
    parameter int unsigned MaxFramesPerCol = 20,
    parameter logic [31:0] SyncWord        = 32'hFAB0_FAB1
) (
    input  logic                       CLK,
    input  logic                       resetn,
    input  logic [31:0]                WriteData,
    input  logic                       WriteValid,
    output logic                       WriteReady,
    output logic [FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic                       Busy,
    output logic                       ConfigDone,
    output logic                       Error
);

    typedef enum logic [2:0] {
        SYNC   = 3'd0,
        HEADER = 3'd1,
        DATA   = 3'd2,
        STROBE = 3'd3,
        DONE   = 3'd4
`ifdef FRAME_CHECKSUM_EN
        , CHECK = 3'd5
`endif
    } state_t;

    localparam logic [7:0] CmdWrite = 8'h01;
    localparam logic [7:0] CmdEnd   = 8'h02;

    state_t                     state, state_d;
    logic [15:0]                idx, idx_d;
    logic [15:0]                cnt, cnt_d;
    logic [FrameBitsPerRow-1:0] frame_data, frame_data_d;
    logic [MaxFramesPerCol-1:0] strobe, strobe_d;
    logic [MaxFramesPerCol-1:0] strobe_dec;
    logic                       done_flag, done_d;
    logic                       error_flag, error_d;
    logic                       xfer;
    logic [7:0]                 hdr_cmd;
    logic [7:0]                 hdr_start;
    logic [15:0]                hdr_count;
    logic [16:0]                range_sum;
    logic                       range_ok;
`ifdef FRAME_CHECKSUM_EN
    logic [31:0]                sum, sum_d;
`endif

    assign WriteReady = (state != STROBE);
    assign Busy       = (state != SYNC) && (state != DONE);
    assign FrameData  = frame_data;
    assign FrameStrobe = strobe;
    assign ConfigDone = done_flag;
    assign Error      = error_flag;

    assign xfer      = WriteValid && WriteReady;
    assign hdr_cmd   = WriteData[31:24];
    assign hdr_start = WriteData[23:16];
    assign hdr_count = WriteData[15:0];
    // 17-bit sum so a large count can never wrap past the column size
    assign range_sum = {9'd0, hdr_start} + {1'b0, hdr_count};
    assign range_ok  = (range_sum <= 17'(MaxFramesPerCol));

    always_comb begin
        strobe_dec = '0;
        for (int i = 0; i < int'(MaxFramesPerCol); i++) begin
            strobe_dec[i] = (idx == 16'(i));
        end
    end

    always_comb begin
        state_d      = state;
        idx_d        = idx;
        cnt_d        = cnt;
        frame_data_d = frame_data;
        strobe_d     = '0;
        done_d       = done_flag;
        error_d      = error_flag;
`ifdef FRAME_CHECKSUM_EN
        sum_d        = sum;
`endif
        case (state)
            SYNC: begin
                if (xfer && WriteData == SyncWord) state_d = HEADER;
            end
            HEADER: begin
                if (xfer) begin
                    if (hdr_cmd == CmdWrite && hdr_count == 16'd0) begin
`ifdef FRAME_CHECKSUM_EN
                        sum_d   = '0;
                        state_d = CHECK;
`else
                        state_d = HEADER;
`endif
                    end else if (hdr_cmd == CmdWrite && range_ok) begin
                        idx_d   = {8'd0, hdr_start};
                        cnt_d   = hdr_count;
`ifdef FRAME_CHECKSUM_EN
                        sum_d   = '0;
`endif
                        state_d = DATA;
                    end else if (hdr_cmd == CmdEnd) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        error_d = 1'b1;
                        state_d = SYNC;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    frame_data_d = FrameBitsPerRow'(WriteData);
                    cnt_d        = cnt - 16'd1;
                    strobe_d     = strobe_dec;
`ifdef FRAME_CHECKSUM_EN
                    sum_d        = sum + WriteData;
`endif
                    state_d      = STROBE;
                end
            end
            STROBE: begin
                idx_d = idx + 16'd1;
                if (cnt == 16'd0) begin
`ifdef FRAME_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = HEADER;
`endif
                end else begin
                    state_d = DATA;
                end
            end
`ifdef FRAME_CHECKSUM_EN
            CHECK: begin
                if (xfer) begin
                    if (sum + WriteData == 32'd0) begin
                        state_d = HEADER;
                    end else begin
                        error_d = 1'b1;
                        state_d = SYNC;
                    end
                end
            end
`endif
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = SYNC;
            end
        endcase
    end

    // Strobe is registered so the latches see a clean single-cycle pulse
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state      <= SYNC;
            idx        <= '0;
            cnt        <= '0;
            frame_data <= '0;
            strobe     <= '0;
            done_flag  <= 1'b0;
            error_flag <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            sum        <= '0;
`endif
        end else begin
            state      <= state_d;
            idx        <= idx_d;
            cnt        <= cnt_d;
            frame_data <= frame_data_d;
            strobe     <= strobe_d;
            done_flag  <= done_d;
            error_flag <= error_d;
`ifdef FRAME_CHECKSUM_EN
            sum        <= sum_d;
`endif
        end
    end

endmodule

// File: tb/tb_frame_config_loader.sv
// Randomised scoreboard bench for frame_config_loader: packets are generated at packet level and the
// expected strobes queued; a negedge monitor pops and compares every strobe the DUT produces.
module tb_frame_config_loader;

    localparam int        MaxFrames = 20;
    localparam logic [31:0] Sync    = 32'hFAB0_FAB1;

    logic                 CLK;
    logic                 resetn;
    logic [31:0]          WriteData;
    logic                 WriteValid;
    logic                 WriteReady;
    logic [31:0]          FrameData;
    logic [MaxFrames-1:0] FrameStrobe;
    logic                 Busy;
    logic                 ConfigDone;
    logic                 Error;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } exp_t;

    exp_t        expQ[$];
    logic [31:0] pktData[$];
    int          total;
    int          bad;

    frame_config_loader dut (
        .CLK        (CLK),
        .resetn     (resetn),
        .WriteData  (WriteData),
        .WriteValid (WriteValid),
        .WriteReady (WriteReady),
        .FrameData  (FrameData),
        .FrameStrobe(FrameStrobe),
        .Busy       (Busy),
        .ConfigDone (ConfigDone),
        .Error      (Error)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Monitor: every strobe the DUT raises must match the head of the scoreboard
    always @(negedge CLK) begin : monitor
        exp_t                 e;
        logic [MaxFrames-1:0] oneHot;
        if (resetn && FrameStrobe != '0) begin
            checkOutput("strobeReadyLow", 32'(WriteReady), 32'd0);
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpectedStrobe: got %h, expected no strobe", FrameStrobe);
            end else begin
                e      = expQ.pop_front();
                oneHot = '0;
                oneHot[e.idx] = 1'b1;
                checkOutput("strobeLine", 32'(FrameStrobe), 32'(oneHot));
                checkOutput("strobeData", FrameData, e.data);
            end
        end
    end

    task automatic doReset();
        resetn     = 1'b0;
        WriteValid = 1'b0;
        WriteData  = '0;
        repeat (3) @(negedge CLK);
        resetn = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            WriteValid = 1'b0;
        end
    endtask

    // Returns right after the rising edge at which the word was transferred
    task automatic sendWord(input logic [31:0] w, input bit jitter);
        int guard;
        guard = 0;
        @(negedge CLK);
        forever begin
            if (jitter && $urandom_range(0, 1) == 0) begin
                WriteValid = 1'b0;
                WriteData  = $urandom;
            end else begin
                WriteData  = w;
                WriteValid = 1'b1;
                if (WriteReady) begin
                    @(posedge CLK);
                    return;
                end
            end
            guard++;
            if (guard > 100) begin
                total++;
                bad++;
                $display("[TB] FAIL handshakeTimeout: got no transfer in %0d cycles, expected transfer", guard);
                WriteValid = 1'b0;
                return;
            end
            @(negedge CLK);
        end
    endtask

    // Write packet: header, n data words (from pktData or random), optional check word
    task automatic applyStimulus(input int start, input int n, input bit jitter);
        logic [31:0] hdr;
        logic [31:0] w;
        logic [31:0] acc;
        exp_t        e;
        hdr = {8'h01, 8'(start), 16'(n)};
        acc = '0;
        sendWord(hdr, jitter);
        for (int i = 0; i < n; i++) begin
            w = (pktData.size() > 0) ? pktData.pop_front() : $urandom;
            acc    = acc + w;
            e.idx  = start + i;
            e.data = w;
            expQ.push_back(e);
            sendWord(w, jitter);
        end
`ifdef FRAME_CHECKSUM_EN
        sendWord(-acc, jitter);
`endif
        if (acc == 32'hFFFF_FFFF) $display("[TB] note: rare data sum");
    endtask

    task automatic checkDrained(input string name);
        idle(4);
        checkOutput(name, 32'(expQ.size()), 32'd0);
        expQ.delete();
    endtask

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int start;
        int n;
        exp_t e;
        total = 0;
        bad   = 0;

        // Reset values
        doReset();
        @(negedge CLK);
        checkOutput("rstReady", 32'(WriteReady), 32'd1);
        checkOutput("rstBusy", 32'(Busy), 32'd0);
        checkOutput("rstStrobe", 32'(FrameStrobe), 32'd0);
        checkOutput("rstData", FrameData, 32'd0);
        checkOutput("rstDone", 32'(ConfigDone), 32'd0);
        checkOutput("rstError", 32'(Error), 32'd0);

        // Directed packet then END
        sendWord(Sync, 1'b0);
        pktData.push_back(32'hDEADBEEF);
        pktData.push_back(32'h12345678);
        applyStimulus(3, 2, 1'b0);
        sendWord(32'h0200_0000, 1'b0);
        checkDrained("basicDrain");
        checkOutput("basicDone", 32'(ConfigDone), 32'd1);
        checkOutput("basicError", 32'(Error), 32'd0);
        checkOutput("basicBusy", 32'(Busy), 32'd0);

        // DONE ignores further traffic
        sendWord(Sync, 1'b0);
        sendWord(32'h0100_0001, 1'b0);
        sendWord(32'hCAFEF00D, 1'b0);
        checkDrained("doneIgnore");
        checkOutput("doneSticky", 32'(ConfigDone), 32'd1);
        checkOutput("doneReady", 32'(WriteReady), 32'd1);

        // Garbage before sync
        doReset();
        sendWord(32'h0000_0000, 1'b0);
        sendWord(32'hFFFF_FFFF, 1'b0);
        idle(2);
        checkOutput("garbageBusy", 32'(Busy), 32'd0);
        sendWord(Sync, 1'b0);
        applyStimulus(0, 3, 1'b0);
        checkDrained("garbageDrain");
        checkOutput("garbageError", 32'(Error), 32'd0);
        checkOutput("headerBusy", 32'(Busy), 32'd1);

        // Out-of-range header, then recovery
        sendWord(32'h0113_0002, 1'b0);
        idle(2);
        checkOutput("rangeError", 32'(Error), 32'd1);
        checkOutput("rangeBusy", 32'(Busy), 32'd0);
        checkDrained("rangeNoStrobe");
        sendWord(Sync, 1'b0);
        applyStimulus(16, 4, 1'b0);
        checkDrained("rangeRecover");

        // Random packets with 50% valid jitter, including empty packets
        doReset();
        sendWord(Sync, 1'b1);
        applyStimulus(0, 4, 1'b1);
        for (int k = 0; k < 10; k++) begin
            start = $urandom_range(0, MaxFrames - 1);
            n     = (k == 5) ? 0 : $urandom_range(1, (MaxFrames - start > 4) ? 4 : MaxFrames - start);
            applyStimulus(start, n, 1'b1);
        end
        checkDrained("randomDrain");
        checkOutput("randomError", 32'(Error), 32'd0);

        // Random bad headers (bad cmd or overrun), each followed by a resync
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) begin
                sendWord({8'($urandom_range(3, 255)), 8'($urandom_range(0, 19)), 16'($urandom_range(1, 4))}, 1'b1);
            end else begin
                start = $urandom_range(1, MaxFrames - 1);
                sendWord({8'h01, 8'(start), 16'(MaxFrames - start + $urandom_range(1, 300))}, 1'b1);
            end
            idle(2);
            checkOutput("badHdrError", 32'(Error), 32'd1);
            checkOutput("badHdrSync", 32'(Busy), 32'd0);
            sendWord(Sync, 1'b1);
            applyStimulus($urandom_range(0, 15), $urandom_range(1, 4), 1'b1);
            checkDrained("badHdrRecover");
        end

        // Reset during the second strobe of a 4-frame packet
        doReset();
        sendWord(Sync, 1'b0);
        sendWord(32'h0102_0004, 1'b0);
        e.idx  = 2;
        e.data = 32'hA5A5_0001;
        expQ.push_back(e);
        sendWord(32'hA5A5_0001, 1'b0);
        sendWord(32'hA5A5_0002, 1'b0);
        #1;
        checkOutput("midStrobeLine", 32'(FrameStrobe), 32'h0000_0008);
        resetn = 1'b0;
        #1;
        checkOutput("cutStrobe", 32'(FrameStrobe), 32'd0);
        checkOutput("cutData", FrameData, 32'd0);
        checkOutput("cutReady", 32'(WriteReady), 32'd1);
        checkOutput("cutBusy", 32'(Busy), 32'd0);
        WriteValid = 1'b0;
        repeat (2) @(negedge CLK);
        resetn = 1'b1;
        checkDrained("cutDrain");
        sendWord(Sync, 1'b0);
        applyStimulus(0, 4, 1'b0);
        checkDrained("afterCut");
        checkOutput("afterCutError", 32'(Error), 32'd0);

`ifdef FRAME_CHECKSUM_EN
        // Check-word match and mismatch
        doReset();
        sendWord(Sync, 1'b0);
        sendWord(32'h0100_0002, 1'b0);
        e.idx = 0; e.data = 32'd1; expQ.push_back(e);
        e.idx = 1; e.data = 32'd2; expQ.push_back(e);
        sendWord(32'd1, 1'b0);
        sendWord(32'd2, 1'b0);
        sendWord(32'hFFFF_FFFD, 1'b0);
        checkDrained("ckGoodDrain");
        checkOutput("ckGoodError", 32'(Error), 32'd0);
        checkOutput("ckGoodBusy", 32'(Busy), 32'd1);
        sendWord(32'h0105_0002, 1'b0);
        e.idx = 5; e.data = 32'd1; expQ.push_back(e);
        e.idx = 6; e.data = 32'd2; expQ.push_back(e);
        sendWord(32'd1, 1'b0);
        sendWord(32'd2, 1'b0);
        sendWord(32'd0, 1'b0);
        checkDrained("ckBadDrain");
        checkOutput("ckBadError", 32'(Error), 32'd1);
        checkOutput("ckBadBusy", 32'(Busy), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
